sram_prog_loader: RTL

- Sits directly upstream of port 0 (RW) of the 32x256 instruction SRAM macro.
- Boot-time program loader: accepts a byte stream (e.g. from the UART receiver), packs bytes little-endian into 32-bit words and writes each word into consecutive SRAM addresses.
- Releases port 0 to the CPU when the load completes. In IDLE, CPU port-0 requests pass straight through to the SRAM.

---
 rtl/sram_prog_loader.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/sram_prog_loader.sv
// rtl/sram_prog_loader.sv - boot loader packing a byte stream into words for SRAM port 0
module sram_prog_loader #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_WMASKS = 4,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic                  clk0,
  input  logic                  resetb,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   num_words,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [31:0]           checksum,
  output logic                  cpu_stall,
  input  logic                  cpu_csb0,
  input  logic                  cpu_web0,
  input  logic [NUM_WMASKS-1:0] cpu_wmask0,
  input  logic [ADDR_WIDTH-1:0] cpu_addr0,
  input  logic [DATA_WIDTH-1:0] cpu_din0,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_WRITE   = 2'd2,
    S_FINISH  = 2'd3
  } state_t;

  // Largest load that fits between BASE_ADDR and the top of the macro.
  localparam logic [ADDR_WIDTH:0] MAX_WORDS =
    (ADDR_WIDTH+1)'((1 << ADDR_WIDTH) - BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

  state_t                  state_q;
  logic [1:0]              byte_idx_q;
  logic [DATA_WIDTH-1:0]   word_q;
  logic [ADDR_WIDTH:0]     count_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [31:0]             checksum_q;
  logic                    done_q;
  logic                    err_q;
  logic                    busy_q;
  logic                    byte_ready_q;

  always_ff @(posedge clk0) begin
    if (!resetb) begin
      state_q      <= S_IDLE;
      byte_idx_q   <= 2'd0;
      word_q       <= '0;
      count_q      <= '0;
      addr_q       <= BASE;
      checksum_q   <= 32'd0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
      byte_ready_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (num_words == '0) begin
              done_q     <= 1'b1;
              err_q      <= 1'b0;
              checksum_q <= 32'd0;
            end else if (num_words > MAX_WORDS) begin
              done_q <= 1'b0;
              err_q  <= 1'b1;
            end else begin
              count_q      <= num_words;
              addr_q       <= BASE;
              byte_idx_q   <= 2'd0;
              checksum_q   <= 32'd0;
              done_q       <= 1'b0;
              err_q        <= 1'b0;
              busy_q       <= 1'b1;
              byte_ready_q <= 1'b1;
              state_q      <= S_COLLECT;
            end
          end
        end
        S_COLLECT: begin
          if (byte_valid && byte_ready_q) begin
            word_q[{byte_idx_q, 3'b000} +: 8] <= byte_data;
            byte_idx_q <= byte_idx_q + 2'd1;
            if (byte_idx_q == 2'd3) begin
              byte_ready_q <= 1'b0;
              state_q      <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          checksum_q <= checksum_q + word_q;
          addr_q     <= addr_q + ADDR_WIDTH'(1);
          count_q    <= count_q - (ADDR_WIDTH+1)'(1);
          byte_idx_q <= 2'd0;
          if (count_q == (ADDR_WIDTH+1)'(1)) begin
            state_q <= S_FINISH;
          end else begin
            byte_ready_q <= 1'b1;
            state_q      <= S_COLLECT;
          end
        end
        S_FINISH: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Port 0 mux: CPU owns it in IDLE, the loader drives it from registers otherwise.
  always_comb begin
    sram_csb0   = 1'b1;
    sram_web0   = 1'b1;
    sram_wmask0 = '0;
    sram_addr0  = addr_q;
    sram_din0   = word_q;
    if (resetb) begin
      if (state_q == S_IDLE) begin
        sram_csb0   = cpu_csb0;
        sram_web0   = cpu_web0;
        sram_wmask0 = cpu_wmask0;
        sram_addr0  = cpu_addr0;
        sram_din0   = cpu_din0;
      end else if (state_q == S_WRITE) begin
        sram_csb0   = 1'b0;
        sram_web0   = 1'b0;
        sram_wmask0 = '1;
      end
    end
  end

  assign byte_ready = byte_ready_q;
  assign busy       = busy_q;
  assign cpu_stall  = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign checksum   = checksum_q;

endmodule
